// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue/response sequencer driving a combinational 4-bit alu, with result accumulator.
// Optional STICKY_FLAGS_EN: accumulate carry/overflow into sticky_cv, cleared by clr_sticky.
module alu_cmd_sequencer #(
  parameter int W          = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_use_acc,
  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_out,
  input  logic [3:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [3:0]   rsp_flags,
  output logic [W-1:0] acc,
  output logic         busy,
  input  logic         clr_sticky,
  output logic [1:0]   sticky_cv
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         use_acc;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  cmd_t            fifo_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  state_t          state_q;
  logic [W-1:0]    in1_q, in2_q, rsp_data_q, acc_q;
  logic [2:0]      op_q;
  logic [3:0]      rsp_flags_q;
  logic            rsp_valid_q;

  cmd_t cmd_in, head;
  logic empty, full, push, pop;

  assign cmd_in = '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};
  assign head   = fifo_q[rd_ptr_q];
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign push   = cmd_valid && !full;
  // Pop only where the FSM loads the issue regs: from IDLE, or on a RESP handshake.
  assign pop    = !empty && (state_q == IDLE || (state_q == RESP && rsp_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= cmd_in;
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in1_q       <= '0;
      in2_q       <= '0;
      op_q        <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            in1_q   <= head.use_acc ? acc_q : head.a;
            in2_q   <= head.b;
            op_q    <= head.op;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data_q  <= alu_out;
          acc_q       <= alu_out;
          rsp_flags_q <= alu_flags;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (pop) begin
              // acc_q already holds the result just handed off, so chaining sees it here.
              in1_q   <= head.use_acc ? acc_q : head.a;
              in2_q   <= head.b;
              op_q    <= head.op;
              state_q <= ISSUE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef STICKY_FLAGS_EN
  logic [1:0] sticky_q;
  logic       capture;
  assign capture = (state_q == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sticky_q <= '0;
    else if (clr_sticky) sticky_q <= capture ? {alu_flags[1], alu_flags[0]} : 2'b00;
    else if (capture)    sticky_q <= sticky_q | {alu_flags[1], alu_flags[0]};
  end
  assign sticky_cv = sticky_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_cv = 2'b00;
`endif

  assign cmd_ready = !full;
  assign busy      = (state_q != IDLE) || !empty;
  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign alu_op    = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign acc       = acc_q;
endmodule
